// File: rtl/nios_cpu_cpu_mul_combine.sv
// ---------------------------------------------------------------------------
// nios_cpu_cpu_mul_combine
//
// Purpose:
//   This stage sits right after the 16x16 multiply cell and finishes the
//   multiply. For MUL it adds the three registered partial products into the
//   32-bit low word in one cycle. For MULXUU, MULXSU and MULXSS it builds the
//   high word of the 64-bit product. The hi*hi partial product comes from a
//   radix-2 shift-add loop of ITER_CYCLES steps. When the loop ends, the
//   signed correction terms are applied. The pipeline is stalled while the
//   loop runs.
//
// Ports:
//   clk               core clock
//   reset_n           asynchronous active-low reset
//   M_en              M-stage advance enable (only matters in IDLE)
//   M_valid           multiply instruction present in M this cycle
//   M_op              00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   M_src1, M_src2    operands A and B, aligned with the cell products
//   M_mul_cell_p1     A[15:0]  * B[15:0]
//   M_mul_cell_p2     A[15:0]  * B[31:16]
//   M_mul_cell_p3     A[31:16] * B[15:0]
//   M_kill            flush: abandon any operation in progress
//   W_mul_result      low word (MUL) or high word (MULX*), held until replaced
//   W_mul_result_vld  one-cycle pulse when W_mul_result is new
//   M_mul_stall       registered, high while the loop is busy (ITER/FIX)
// ---------------------------------------------------------------------------
module nios_cpu_cpu_mul_combine #(
  parameter int ITER_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M_en,
  input  logic        M_valid,
  input  logic [1:0]  M_op,
  input  logic [31:0] M_src1,
  input  logic [31:0] M_src2,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic        M_kill,
  output logic [31:0] W_mul_result,
  output logic        W_mul_result_vld,
  output logic        M_mul_stall
);

  localparam int CNT_W = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       a_reg, b_reg;
  logic [1:0]        op_reg;
  logic [33:0]       mid_reg;
  logic [31:0]       p4_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       result_reg;
  logic              vld_reg;
  logic              stall_reg;

  logic              accept;
  logic [31:0]       mul_lo;
  logic [33:0]       mid_next;
  logic [15:0]       a_hi, b_hi;
  logic [31:0]       p4_next;
  logic [31:0]       hu;

  assign accept = (state_reg == IDLE) && M_valid && M_en && !M_kill;

  // Low word: the cross terms land at bit 16. Bits that overflow past bit 31
  // are dropped on purpose.
  assign mul_lo = M_mul_cell_p1 + ((M_mul_cell_p2 + M_mul_cell_p3) << 16);

  // Middle column keeps its carries (34 bits). Bits [33:16] feed the high word.
  assign mid_next = {18'b0, M_mul_cell_p1[31:16]} + {2'b0, M_mul_cell_p2}
                  + {2'b0, M_mul_cell_p3};

  assign a_hi = a_reg[31:16];
  assign b_hi = b_reg[31:16];

  // One shift-add step. The counter selects the multiplier bit and the shift.
  assign p4_next = p4_reg + (b_hi[cnt_reg] ? ({16'b0, a_hi} << cnt_reg) : 32'b0);

  // Unsigned high word. Subtracting B (or A) undoes the weight 2^32 that an
  // operand's sign bit received when it was treated as unsigned.
  always_comb begin
    hu = p4_reg + {14'b0, mid_reg[33:16]};
    if (op_reg[1] && a_reg[31]) begin
      hu = hu - b_reg;
    end
    if ((op_reg == 2'b11) && b_reg[31]) begin
      hu = hu - a_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && (M_op != 2'b00)) begin
          state_next = ITER;
        end
      end
      ITER: begin
        if (M_kill) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      stall_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      stall_reg <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg      <= 32'b0;
      b_reg      <= 32'b0;
      op_reg     <= 2'b0;
      mid_reg    <= 34'b0;
      p4_reg     <= 32'b0;
      cnt_reg    <= '0;
      result_reg <= 32'b0;
      vld_reg    <= 1'b0;
    end else begin
      vld_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (M_op == 2'b00) begin
              result_reg <= mul_lo;
              vld_reg    <= 1'b1;
            end else begin
              a_reg   <= M_src1;
              b_reg   <= M_src2;
              op_reg  <= M_op;
              mid_reg <= mid_next;
              p4_reg  <= 32'b0;
              cnt_reg <= '0;
            end
          end
        end
        ITER: begin
          if (!M_kill) begin
            p4_reg  <= p4_next;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        FIX: begin
          if (!M_kill) begin
            result_reg <= hu;
            vld_reg    <= 1'b1;
          end
        end
        default: begin
          vld_reg <= 1'b0;
        end
      endcase
    end
  end

  assign W_mul_result     = result_reg;
  assign W_mul_result_vld = vld_reg;
  assign M_mul_stall      = stall_reg;

endmodule

// File: tb/tb_nios_cpu_cpu_mul_combine.sv
// ---------------------------------------------------------------------------
// tb_nios_cpu_cpu_mul_combine
//
// Directed test of the multiply combine stage. The bench forms the cell
// partial products from the operands, the way the real cell would. The
// expected results are constants worked out by hand.
// ---------------------------------------------------------------------------
module tb_nios_cpu_cpu_mul_combine;

  logic        clk;
  logic        reset_n;
  logic        M_en;
  logic        M_valid;
  logic [1:0]  M_op;
  logic [31:0] M_src1;
  logic [31:0] M_src2;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic        M_kill;
  logic [31:0] W_mul_result;
  logic        W_mul_result_vld;
  logic        M_mul_stall;

  int checks;
  int errors;

  nios_cpu_cpu_mul_combine #(.ITER_CYCLES(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .M_en             (M_en),
    .M_valid          (M_valid),
    .M_op             (M_op),
    .M_src1           (M_src1),
    .M_src2           (M_src2),
    .M_mul_cell_p1    (M_mul_cell_p1),
    .M_mul_cell_p2    (M_mul_cell_p2),
    .M_mul_cell_p3    (M_mul_cell_p3),
    .M_kill           (M_kill),
    .W_mul_result     (W_mul_result),
    .W_mul_result_vld (W_mul_result_vld),
    .M_mul_stall      (M_mul_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Wait for the next rising edge, then step 1 time unit past it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive operands and the matching cell products for one cycle.
  task automatic drive(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic en, input logic kill);
    M_valid       = 1'b1;
    M_en          = en;
    M_kill        = kill;
    M_op          = op;
    M_src1        = a;
    M_src2        = b;
    M_mul_cell_p1 = {16'b0, a[15:0]} * {16'b0, b[15:0]};
    M_mul_cell_p2 = {16'b0, a[15:0]} * {16'b0, b[31:16]};
    M_mul_cell_p3 = {16'b0, a[31:16]} * {16'b0, b[15:0]};
  endtask

  task automatic idle_inputs;
    M_valid = 1'b0;
    M_en    = 1'b1;
    M_kill  = 1'b0;
  endtask

  // Called 1 time unit after a rising edge. The accept happens in the
  // current cycle T. The task returns 1 time unit after the edge that
  // starts the cycle in which vld is expected.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expected);
    drive(op, a, b, 1'b1, 1'b0);
    step();
    idle_inputs();
    if (op != 2'b00) begin
      for (int k = 1; k <= 17; k++) begin
        check({tag, " stall busy"}, {31'b0, M_mul_stall}, 32'd1);
        check({tag, " vld early"}, {31'b0, W_mul_result_vld}, 32'd0);
        step();
      end
    end
    check({tag, " vld"}, {31'b0, W_mul_result_vld}, 32'd1);
    check({tag, " stall done"}, {31'b0, M_mul_stall}, 32'd0);
    check({tag, " result"}, W_mul_result, expected);
    $display("op %s: op=%0d a=0x%08h b=0x%08h result=0x%08h", tag, op, a, b,
             W_mul_result);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    M_op = 2'b00; M_src1 = 32'b0; M_src2 = 32'b0;
    M_mul_cell_p1 = 32'b0; M_mul_cell_p2 = 32'b0; M_mul_cell_p3 = 32'b0;
    idle_inputs();
    step();
    step();
    check("reset result", W_mul_result, 32'h0);
    check("reset vld", {31'b0, W_mul_result_vld}, 32'd0);
    check("reset stall", {31'b0, M_mul_stall}, 32'd0);
    reset_n = 1'b1;
    step();

    // Tests 1-3: all-ones operands, every opcode.
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    check("mul_ff vld single", {31'b0, W_mul_result_vld}, 32'd0);
    run_op("mulxuu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    step();
    check("mulxuu vld single", {31'b0, W_mul_result_vld}, 32'd0);
    check("mulxuu result held", W_mul_result, 32'hFFFF_FFFE);
    run_op("mulxsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulxss_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

    // Test 4: 2^16 * 2^16. The back-to-back MUL is accepted at T+18.
    run_op("mul_2p16", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_op("mulxuu_2p16", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    run_op("mul_b2b", 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

    // A mixed-sign MULXSS: (-2) * 3 = -6, so the high word is all ones.
    run_op("mulxss_mix", 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
    run_op("mul_prior", 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

    // M_en low in IDLE: no accept.
    drive(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    step();
    idle_inputs();
    check("en_low stall", {31'b0, M_mul_stall}, 32'd0);
    check("en_low vld", {31'b0, W_mul_result_vld}, 32'd0);

    // A kill in the same cycle as an accept wins: nothing is accepted.
    drive(2'b00, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1);
    step();
    idle_inputs();
    check("kill_accept vld", {31'b0, W_mul_result_vld}, 32'd0);
    check("kill_accept result", W_mul_result, 32'h0000_000F);
    $display("op kill_accept: result=0x%08h", W_mul_result);

    // Test 5: MULXUU killed at T+9.
    drive(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      check("kill stall pre", {31'b0, M_mul_stall}, 32'd1);
      step();
    end
    M_kill = 1'b1;
    step();
    M_kill = 1'b0;
    check("kill stall drop", {31'b0, M_mul_stall}, 32'd0);
    check("kill no vld", {31'b0, W_mul_result_vld}, 32'd0);
    check("kill result kept", W_mul_result, 32'h0000_000F);
    for (int k = 0; k < 12; k++) begin
      check("kill no late vld", {31'b0, W_mul_result_vld}, 32'd0);
      step();
    end
    $display("op kill_iter: result=0x%08h", W_mul_result);

    // Test 6: reset asserted at T+5 of a MULXSS.
    drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step();
    idle_inputs();
    repeat (4) step();
    check("rst_mid stall before", {31'b0, M_mul_stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid result", W_mul_result, 32'h0);
    check("rst_mid vld", {31'b0, W_mul_result_vld}, 32'd0);
    check("rst_mid stall", {31'b0, M_mul_stall}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("rst_mid no partial vld", {31'b0, W_mul_result_vld}, 32'd0);
      step();
    end
    $display("op reset_mid: result=0x%08h", W_mul_result);
    run_op("mul_after_rst", 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
